// File: rtl/aemb2_ramarb.sv
// Purpose : two-port (A/B) arbiter in front of one single-port, async-read RAM.
// Latency : stb sampled in IDLE -> BUSY (RAM access) -> ACK pulse, 2 cycles best case.
// Backpressure: ena_i=0 freezes state, grant, priority, ack and read data; RAM write suppressed.
//
// Ports
//   clk_i, rst_i (sync, active-high), ena_i (global enable)
//   a_*/b_*   : requester ports, stb/wre/adr/dat held until ack; dat_o is registered read data
//   ram_*     : single-port RAM, combinational address/write data/write enable, async read data
//
// Build option
//   AEMB2_RAMARB_RR_EN defined   : round-robin between simultaneous eligible requests
//   AEMB2_RAMARB_RR_EN undefined : fixed priority, A wins simultaneous requests
module aemb2_ramarb #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,

    input  logic          a_stb_i,
    input  logic          a_wre_i,
    input  logic [AW-1:0] a_adr_i,
    input  logic [DW-1:0] a_dat_i,
    output logic [DW-1:0] a_dat_o,
    output logic          a_ack_o,

    input  logic          b_stb_i,
    input  logic          b_wre_i,
    input  logic [AW-1:0] b_adr_i,
    input  logic [DW-1:0] b_dat_i,
    output logic [DW-1:0] b_dat_o,
    output logic          b_ack_o,

    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    input  logic [DW-1:0] ram_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_gnt;        // 0 = A, 1 = B
    logic          w_gnt_nxt;
    logic          r_pri;        // port preferred on a tie; stays 0 (A) in fixed-priority builds
    logic          w_pri_nxt;
    logic          r_a_ack;
    logic          r_b_ack;
    logic [DW-1:0] r_a_dat;
    logic [DW-1:0] r_b_dat;

    logic          w_req_a;      // A eligible for a grant this cycle
    logic          w_req_b;      // B eligible for a grant this cycle
    logic          w_grant;      // some eligible request exists
    logic          w_sel;        // port that would be granted
    logic          w_busy;

    assign w_busy = (r_state == S_BUSY);

    // Eligibility and arbitration. In ACK the port being acknowledged is
    // excluded, so the other port always gets the very next slot.
    always_comb begin
        w_req_a = 1'b0;
        w_req_b = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_a = a_stb_i;
                w_req_b = b_stb_i;
            end
            S_ACK: begin
                w_req_a = a_stb_i & r_gnt;
                w_req_b = b_stb_i & ~r_gnt;
            end
            default: begin
                w_req_a = 1'b0;
                w_req_b = 1'b0;
            end
        endcase
        w_grant = w_req_a | w_req_b;
        w_sel   = (w_req_a & w_req_b) ? r_pri : w_req_b;
    end

    // Next-state, grant and priority pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_pri_nxt   = r_pri;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = w_sel;
                end
            end
            S_BUSY: begin
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (w_grant) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = w_sel;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef AEMB2_RAMARB_RR_EN
        // Each grant hands the tie-break to the port that was not just served.
        if (w_grant) begin
            w_pri_nxt = ~w_sel;
        end
`else
        w_pri_nxt = 1'b0;
`endif
    end

    // State, grant, ack and read-data registers. Reset overrides the enable;
    // a capture in the reset cycle is discarded by the reset branch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_pri   <= 1'b0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_a_dat <= '0;
            r_b_dat <= '0;
        end else if (ena_i) begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_pri   <= w_pri_nxt;
            r_a_ack <= w_busy & ~r_gnt;
            r_b_ack <= w_busy & r_gnt;
            if (w_busy && !r_gnt && !a_wre_i) begin
                r_a_dat <= ram_dat_i;
            end
            if (w_busy && r_gnt && !b_wre_i) begin
                r_b_dat <= ram_dat_i;
            end
        end
    end

    // RAM side: the granted port only while BUSY, port A otherwise.
    assign ram_adr_o = (w_busy && r_gnt) ? b_adr_i : a_adr_i;
    assign ram_dat_o = (w_busy && r_gnt) ? b_dat_i : a_dat_i;
    assign ram_wre_o = w_busy & ena_i & (r_gnt ? b_wre_i : a_wre_i);

    assign a_ack_o = r_a_ack;
    assign b_ack_o = r_b_ack;
    assign a_dat_o = r_a_dat;
    assign b_dat_o = r_b_dat;

endmodule

// File: tb/tb_aemb2_ramarb.sv
// Purpose : bench for aemb2_ramarb with a behavioural RAM, directed scenarios and random traffic.
// Latency : n/a (bench).
// Backpressure: drives ena_i low at random; transfers complete on ack_o with ena_i high.
module tb_aemb2_ramarb;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef AEMB2_RAMARB_RR_EN
    localparam bit FIRST_A = 1'b0;
`else
    localparam bit FIRST_A = 1'b1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ena_i;
    logic          a_stb_i, b_stb_i, a_wre_i, b_wre_i;
    logic [AW-1:0] a_adr_i, b_adr_i, ram_adr_o;
    logic [DW-1:0] a_dat_i, b_dat_i, a_dat_o, b_dat_o, ram_dat_o, ram_dat_i;
    logic          a_ack_o, b_ack_o, ram_wre_o;

    logic [DW-1:0] mem [32];
    logic          mem_init = 1'b0;
    int            wr_cnt = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    aemb2_ramarb #(.AW(AW), .DW(DW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ena_i    (ena_i),
        .a_stb_i  (a_stb_i),
        .a_wre_i  (a_wre_i),
        .a_adr_i  (a_adr_i),
        .a_dat_i  (a_dat_i),
        .a_dat_o  (a_dat_o),
        .a_ack_o  (a_ack_o),
        .b_stb_i  (b_stb_i),
        .b_wre_i  (b_wre_i),
        .b_adr_i  (b_adr_i),
        .b_dat_i  (b_dat_i),
        .b_dat_o  (b_dat_o),
        .b_ack_o  (b_ack_o),
        .ram_adr_o(ram_adr_o),
        .ram_dat_o(ram_dat_o),
        .ram_wre_o(ram_wre_o),
        .ram_dat_i(ram_dat_i)
    );

    // Behavioural single-port RAM: async read, write on the rising edge.
    assign ram_dat_i = mem[ram_adr_o];
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i) * 32'h01010101;
        end else if (ram_wre_o) begin
            mem[ram_adr_o] <= ram_dat_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        a_stb_i = 1'b0; a_wre_i = 1'b0; a_adr_i = '0; a_dat_i = '0;
        b_stb_i = 1'b0; b_wre_i = 1'b0; b_adr_i = '0; b_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Random-traffic model: per-port transaction state plus a shadow memory
    // updated in completion order.
    logic [DW-1:0] shadow [32];
    bit            act [2];
    bit            wre [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic [DW-1:0] expd [2];
    int            wt [2];
    int            gap [2];
    bit            done [2];
    logic          ack [2];
    logic [DW-1:0] dq [2];
    bit            stop_new;
    bit            force_ena;
    int            nwr;
    int            w_base;

    task automatic observe();
        @(negedge clk_i);
        ack[0] = a_ack_o; ack[1] = b_ack_o;
        dq[0]  = a_dat_o; dq[1]  = b_dat_o;
        if (!ena_i) check("rnd_stall_wre", ram_wre_o, 0);
        check("rnd_ack_excl", a_ack_o & b_ack_o, 0);
        for (int p = 0; p < 2; p++) begin
            done[p] = 1'b0;
            if (ack[p] && !act[p])
                check($sformatf("rnd_spurious_ack%0d", p), ack[p], 0);
            else if (ack[p] && !wre[p])
                check($sformatf("rnd_rd_dat%0d", p), dq[p], shadow[adr[p]]);
            else
                check($sformatf("rnd_dat_hold%0d", p), dq[p], expd[p]);
            if (act[p] && ena_i) begin
                if (ack[p]) begin
                    check($sformatf("rnd_latency%0d", p), wt[p] <= 4, 1);
                    if (wre[p]) begin
                        shadow[adr[p]] = dat[p];
                        nwr++;
                    end else begin
                        expd[p] = shadow[adr[p]];
                    end
                    done[p] = 1'b1;
                end else begin
                    wt[p]++;
                    if (wt[p] == 8) check($sformatf("rnd_timeout%0d", p), wt[p], 4);
                end
            end
        end
    endtask

    task automatic update_stim();
        tick();
        for (int p = 0; p < 2; p++) begin
            if (done[p]) begin
                act[p] = 1'b0;
                wt[p]  = 0;
                gap[p] = int'($urandom_range(0, 2));
            end else if (!act[p]) begin
                if (gap[p] > 0) gap[p]--;
                else if (!stop_new && $urandom_range(0, 1) == 1) begin
                    act[p] = 1'b1;
                    wre[p] = 1'($urandom_range(0, 1));
                    adr[p] = AW'($urandom_range(0, 31));
                    dat[p] = $urandom;
                    wt[p]  = 0;
                end
            end
        end
        ena_i   = force_ena ? 1'b1 : ($urandom_range(0, 99) < 85);
        a_stb_i = act[0]; a_wre_i = wre[0]; a_adr_i = adr[0]; a_dat_i = dat[0];
        b_stb_i = act[1]; b_wre_i = wre[1]; b_adr_i = adr[1]; b_dat_i = dat[1];
    endtask

    initial begin
        rst_i = 1'b1;
        ena_i = 1'b1;
        idle_inputs();
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        check("rst_a_ack", a_ack_o, 0);
        check("rst_b_ack", b_ack_o, 0);
        check("rst_a_dat", a_dat_o, 0);
        check("rst_b_dat", b_dat_o, 0);
        check("rst_wre",   ram_wre_o, 0);
        rst_i = 1'b0;

        // Write on A.
        a_stb_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 5'd3; a_dat_i = 32'hDEADBEEF;
        tick();
        check("wrA_c1_wre", ram_wre_o, 1);
        check("wrA_c1_adr", ram_adr_o, 3);
        check("wrA_c1_dat", ram_dat_o, 32'hDEADBEEF);
        check("wrA_c1_ack", a_ack_o, 0);
        tick();
        check("wrA_c2_aack", a_ack_o, 1);
        check("wrA_c2_back", b_ack_o, 0);
        check("wrA_mem", mem[3], 32'hDEADBEEF);
        a_stb_i = 1'b0; a_wre_i = 1'b0;
        tick();
        check("wrA_pulse", a_ack_o, 0);

        // Read back on B.
        b_stb_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd3;
        tick();
        check("rdB_c1_adr", ram_adr_o, 3);
        check("rdB_c1_wre", ram_wre_o, 0);
        check("rdB_c1_ack", b_ack_o, 0);
        tick();
        check("rdB_c2_back", b_ack_o, 1);
        check("rdB_c2_aack", a_ack_o, 0);
        check("rdB_dat", b_dat_o, 32'hDEADBEEF);
        check("rdB_a_dat_kept", a_dat_o, 0);
        b_stb_i = 1'b0;
        tick();

        // Tie after an A access.
        a_stb_i = 1'b1; a_wre_i = 1'b0; a_adr_i = 5'd3;
        tick();
        tick();
        check("pre_tie_aack", a_ack_o, 1);
        check("pre_tie_adat", a_dat_o, 32'hDEADBEEF);
        a_stb_i = 1'b0;
        tick();
        a_stb_i = 1'b1; a_adr_i = 5'd3;
        b_stb_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd4;
        tick();
        check("tie_busy_adr", ram_adr_o, FIRST_A ? 3 : 4);
        tick();
        check("tie_first_aack", a_ack_o, FIRST_A);
        check("tie_first_back", b_ack_o, !FIRST_A);
        if (FIRST_A) a_stb_i = 1'b0; else b_stb_i = 1'b0;
        tick();
        tick();
        check("tie_second_aack", a_ack_o, !FIRST_A);
        check("tie_second_back", b_ack_o, FIRST_A);
        check("tie_b_dat", b_dat_o, 32'h04040404);
        idle_inputs();
        tick();

        // Both requesters held from reset: strict alternation.
        a_stb_i = 1'b1; a_adr_i = 5'd1;
        b_stb_i = 1'b1; b_adr_i = 5'd2;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("alt_a_c%0d", k), a_ack_o, (k % 4) == 2);
            check($sformatf("alt_b_c%0d", k), b_ack_o, (k % 4) == 0);
        end
        idle_inputs();
        do_reset();

        // Stall for 3 cycles in BUSY of a write.
        begin
            int w0;
            w0 = wr_cnt;
            a_stb_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 5'd10; a_dat_i = 32'h12345678;
            tick();
            check("stall_c1_wre", ram_wre_o, 1);
            ena_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #1;
                check($sformatf("stall_wre_%0d", k), ram_wre_o, 0);
                check($sformatf("stall_ack_%0d", k), a_ack_o, 0);
                tick();
            end
            ena_i = 1'b1;
            #1;
            check("stall_resume_wre", ram_wre_o, 1);
            check("stall_resume_ack", a_ack_o, 0);
            tick();
            check("stall_ack", a_ack_o, 1);
            check("stall_one_write", wr_cnt - w0, 1);
            check("stall_mem", mem[10], 32'h12345678);
            ena_i = 1'b0;
            tick();
            check("stall_ack_held", a_ack_o, 1);
            check("stall_still_one_write", wr_cnt - w0, 1);
            a_stb_i = 1'b0; a_wre_i = 1'b0;
            ena_i = 1'b1;
            tick();
            check("stall_ack_drop", a_ack_o, 0);
        end

        // Reset during BUSY of a read on B.
        tick();
        a_adr_i = 5'd9;
        b_stb_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd3;
        tick();
        check("rstB_busy_adr", ram_adr_o, 3);
        rst_i = 1'b1;
        tick();
        check("rstB_no_ack", b_ack_o, 0);
        check("rstB_dat_clr", b_dat_o, 0);
        check("rstB_idle_adr", ram_adr_o, 9);
        rst_i = 1'b0;
        tick();
        check("rstB_regrant_adr", ram_adr_o, 3);
        check("rstB_regrant_ack0", b_ack_o, 0);
        tick();
        check("rstB_regrant_ack", b_ack_o, 1);
        check("rstB_regrant_dat", b_dat_o, 32'hDEADBEEF);
        idle_inputs();
        tick();

        // Random traffic against the shadow model.
        do_reset();
        for (int i = 0; i < 32; i++) shadow[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; wre[p] = 1'b0; adr[p] = '0; dat[p] = '0;
            expd[p] = '0; wt[p] = 0; gap[p] = 0; done[p] = 1'b0;
        end
        stop_new  = 1'b0;
        force_ena = 1'b0;
        nwr       = 0;
        w_base    = wr_cnt;
        for (int c = 0; c < 3000; c++) begin
            observe();
            update_stim();
        end
        stop_new  = 1'b1;
        force_ena = 1'b1;
        for (int c = 0; c < 16; c++) begin
            observe();
            update_stim();
        end
        check("rnd_drained", act[0] | act[1], 0);
        check("rnd_wr_count", wr_cnt - w_base, nwr);
        for (int i = 0; i < 32; i++) check($sformatf("rnd_mem%0d", i), mem[i], shadow[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
